// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RV32I instruction-fetch stage.
// Holds the PC, issues one word-aligned request per cycle over a req/ready
// handshake and captures the returned word into the IF/ID register.
// A redirect from ID flushes the slot at the cost of one bubble.
// Optional feature macro: IF_FETCH_PERF_CNT_EN adds fetch/flush counters.
//
// state | meaning
// BOOT  | just out of reset, no request issued, registers at reset values
// RUN   | normal fetch operation
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic ST_BOOT = 1'b0;
  localparam logic ST_RUN  = 1'b1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        r_state;
  logic [31:0] r_pc;
  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_instr;

  logic w_run;
  logic w_slot_free;
  logic w_req;
  logic w_fire;
  logic w_unused_pc_lsbs;

  assign w_run       = (r_state == ST_RUN);
  assign w_slot_free = !r_id_valid || !id_stall;
  assign w_req       = w_run && !redirect_valid && w_slot_free;
  assign w_fire      = w_req && imem_ready;

  // Redirect targets are forced word-aligned, so the low bits are dropped.
  assign w_unused_pc_lsbs = ^redirect_pc[1:0];

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign id_valid  = r_id_valid;
  assign id_pc     = r_id_pc;
  assign id_instr  = r_id_instr;

  // BOOT lasts exactly one edge after reset release, then RUN forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= ST_RUN;
    end
  end

  // PC and IF/ID slot update: redirect > fire > drain > hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_id_valid <= 1'b0;
      r_id_pc    <= 32'h0;
      r_id_instr <= NOP;
    end else if (!w_run) begin
      r_pc       <= RESET_PC;
      r_id_valid <= 1'b0;
      r_id_pc    <= 32'h0;
      r_id_instr <= NOP;
    end else if (redirect_valid) begin
      // id_pc/id_instr are left as-is; they are don't-care while the slot is empty.
      r_pc       <= {redirect_pc[31:2], 2'b00};
      r_id_valid <= 1'b0;
    end else if (w_fire) begin
      r_pc       <= r_pc + 32'd4;
      r_id_valid <= 1'b1;
      r_id_pc    <= r_pc;
      r_id_instr <= imem_rdata;
    end else if (w_slot_free) begin
      r_id_valid <= 1'b0;
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_flush_cnt = r_flush_cnt;

  // Count accepted fetches and redirects that squashed a pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= 32'h0;
      r_flush_cnt <= 32'h0;
    end else begin
      if (w_fire) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (redirect_valid && w_run && w_slot_free) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed test-plan sequence followed by
// randomized traffic, all checked against a behavioural model of the stage.
module tb_if_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  if_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_stall(id_stall),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr)
`ifdef IF_FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the architectural state of the fetch stage.
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_instr;
  logic [31:0] m_fetches;
  logic [31:0] m_flushes;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pc = RST_PC; m_valid = 0;
    m_id_pc = 32'h0; m_id_instr = NOP;
    m_fetches = 0; m_flushes = 0;
  endtask

  function automatic bit model_slot_free();
    return !m_valid || !id_stall;
  endfunction

  function automatic bit model_req();
    return m_run && !redirect_valid && model_slot_free();
  endfunction

  task automatic check_outputs(input string ph);
    chk({ph, ".req"},   {31'h0, imem_req}, {31'h0, model_req()});
    chk({ph, ".addr"},  imem_addr, m_pc);
    chk({ph, ".valid"}, {31'h0, id_valid}, {31'h0, m_valid});
    if (m_valid) begin
      chk({ph, ".id_pc"},    id_pc, m_id_pc);
      chk({ph, ".id_instr"}, id_instr, m_id_instr);
    end
`ifdef IF_FETCH_PERF_CNT_EN
    chk({ph, ".perf_fetch"}, perf_fetch_cnt, m_fetches);
    chk({ph, ".perf_flush"}, perf_flush_cnt, m_flushes);
`endif
  endtask

  task automatic model_edge();
    bit sf, rq;
    sf = model_slot_free();
    rq = model_req();
    if (!m_run) begin
      m_run = 1;
    end else if (redirect_valid) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_valid = 0;
      if (sf) m_flushes = m_flushes + 1;
    end else if (rq && imem_ready) begin
      m_id_pc = m_pc;
      m_id_instr = imem_rdata;
      m_valid = 1;
      m_pc = m_pc + 32'd4;
      m_fetches = m_fetches + 1;
    end else if (sf) begin
      m_valid = 0;
    end
  endtask

  // One cycle: drive at the falling edge, check mid-cycle, model the rising edge.
  task automatic step(input string ph, input logic rdy, input logic stl,
                      input logic rv, input logic [31:0] rp);
    imem_ready = rdy; id_stall = stl; redirect_valid = rv; redirect_pc = rp;
    imem_rdata = $urandom;
    #1;
    check_outputs(ph);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; id_stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; imem_rdata = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst.req",   {31'h0, imem_req}, 32'h0);
    chk("rst.addr",  imem_addr, RST_PC);
    chk("rst.valid", {31'h0, id_valid}, 32'h0);
    chk("rst.id_pc", id_pc, 32'h0);
    chk("rst.instr", id_instr, NOP);
    @(negedge clk);
    rst_n = 1'b1;

    // Boot edge, then streaming fetch.
    step("boot", 1, 0, 0, 0);
    step("run0", 1, 0, 0, 0);
    chk("run0.id_pc", id_pc, 32'h100);
    step("run1", 1, 0, 0, 0);
    chk("run1.addr", imem_addr, 32'h108);

    // Memory wait at 0x108.
    for (int i = 0; i < 3; i++) step("wait", 0, 0, 0, 0);
    chk("wait.addr", imem_addr, 32'h108);
    chk("wait.valid", {31'h0, id_valid}, 32'h0);
    step("wait_go", 1, 0, 0, 0);
    chk("wait_go.id_pc", id_pc, 32'h108);
    step("pre_stall", 1, 0, 0, 0);
    chk("pre_stall.id_pc", id_pc, 32'h10C);

    // Stall with valid slot.
    for (int i = 0; i < 2; i++) step("stall", 1, 1, 0, 0);
    chk("stall.id_pc", id_pc, 32'h10C);
    chk("stall.addr", imem_addr, 32'h110);
    step("unstall", 1, 0, 0, 0);
    chk("unstall.id_pc", id_pc, 32'h110);

    // Redirect to 0x200.
    step("redir", 1, 0, 1, 32'h200);
    chk("redir.valid", {31'h0, id_valid}, 32'h0);
    chk("redir.addr", imem_addr, 32'h200);
    step("redir_fetch", 1, 0, 0, 0);
    chk("redir_fetch.id_pc", id_pc, 32'h200);
`ifdef IF_FETCH_PERF_CNT_EN
    chk("redir.perf_flush", perf_flush_cnt, 32'h1);
`endif

    // Redirect beats stall, unaligned target.
    step("redir_stall", 1, 1, 1, 32'h303);
    chk("redir_stall.addr", imem_addr, 32'h300);
    chk("redir_stall.valid", {31'h0, id_valid}, 32'h0);

    // PC wrap.
    step("wrap_redir", 1, 0, 1, 32'hFFFF_FFFC);
    step("wrap_fetch", 1, 0, 0, 0);
    chk("wrap.addr", imem_addr, 32'h0);
    chk("wrap.id_pc", id_pc, 32'hFFFF_FFFC);
    step("wrap_next", 1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom % 4) != 0, ($urandom % 3) == 0,
           ($urandom % 8) == 0, $urandom);
    end

    // Asynchronous reset in the middle of a wait with a stalled slot.
    step("pre_arst", 0, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.valid", {31'h0, id_valid}, 32'h0);
    chk("arst.addr", imem_addr, RST_PC);
    chk("arst.req", {31'h0, imem_req}, 32'h0);
`ifdef IF_FETCH_PERF_CNT_EN
    chk("arst.perf_fetch", perf_fetch_cnt, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step("reboot", 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("after", 1, 0, 0, 0);
    chk("after.id_pc", id_pc, 32'h10C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
